// File: rtl/recirculacion_retorno_pkg.sv
// Shared types for the recirculation return path: lane/word layout and FSM states.
package recirculacion_retorno_pkg;

   localparam int LANES  = 4;
   localparam int LANE_W = 8;

   typedef struct packed {
      logic              valid;
      logic [LANE_W-1:0] data;
   } lane_t;

   // Lane 0 sits in the least significant 9 bits.
   typedef lane_t [LANES-1:0] word_t;

   localparam int WORD_W = $bits(word_t);

   typedef enum logic [1:0] {
      PASS   = 2'd0,
      RECIRC = 2'd1,
      REPLAY = 2'd2
   } state_e;

   function automatic logic word_valid(input word_t w);
      logic v;
      v = 1'b0;
      for (int i = 0; i < LANES; i++) v |= w[i].valid;
      return v;
   endfunction

endpackage

// File: rtl/recirculacion_retorno_fifo_recirc.sv
// Replay FIFO (fifo_recirc): DEPTH words of WORD_W bits, registered pointers, no fall-through.
module recirculacion_retorno_fifo_recirc
   import recirculacion_retorno_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic        clk,
   input  logic        reset_L,
   input  logic        push,
   input  word_t       wr_word,
   input  logic        pop,
   output word_t       rd_word,
   output logic [AW:0] count,
   output logic [AW:0] count_nxt,
   output logic        full,
   output logic        empty
);

   word_t         mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   // A pop on the same edge frees the slot, so a full FIFO may still accept.
   assign do_push = push && (!full || do_pop);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; emptiness is tracked by count_q, so stale words are never read out.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_word;
   end

   assign rd_word   = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign count_nxt = count_d;

endmodule

// File: rtl/recirculacion_retorno.sv
// Return end of the recirculation loop: buffers bounced words and replays them ahead of new stimulus.
// Optional statistics ports are enabled with `define RECIRC_STATS_EN.
module recirculacion_retorno
   import recirculacion_retorno_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic         clk,
   input  logic         reset_L,
   input  logic [7:0]   data_0in,
   input  logic [7:0]   data_1in,
   input  logic [7:0]   data_2in,
   input  logic [7:0]   data_3in,
   input  logic         valid_0in,
   input  logic         valid_1in,
   input  logic         valid_2in,
   input  logic         valid_3in,
   output logic         ready_in,
   input  logic [7:0]   data_0rp,
   input  logic [7:0]   data_1rp,
   input  logic [7:0]   data_2rp,
   input  logic [7:0]   data_3rp,
   input  logic         valid_0rp,
   input  logic         valid_1rp,
   input  logic         valid_2rp,
   input  logic         valid_3rp,
   input  logic         IDLE_OUT,
   output logic [7:0]   data_0ps,
   output logic [7:0]   data_1ps,
   output logic [7:0]   data_2ps,
   output logic [7:0]   data_3ps,
   output logic         valid_0ps,
   output logic         valid_1ps,
   output logic         valid_2ps,
   output logic         valid_3ps,
`ifdef RECIRC_STATS_EN
   output logic [15:0]  recirc_total,
   output logic [AW:0]  max_count,
`endif
   output logic [AW:0]  fifo_count,
   output logic         overflow_err
);

   localparam logic [AW:0] RESERVE_LIM = (AW+1)'(DEPTH - 1);

   word_t       in_word, rp_word, rd_word;
   word_t       ps_q, ps_d;
   state_e      state_q, state_d, mode;
   logic        push, pop, pop_ok, push_wr;
   logic        fifo_full, fifo_empty;
   logic [AW:0] count_nxt;
   logic        overflow_err_q, overflow_err_d;

   assign in_word = {{valid_3in, data_3in}, {valid_2in, data_2in},
                     {valid_1in, data_1in}, {valid_0in, data_0in}};
   assign rp_word = {{valid_3rp, data_3rp}, {valid_2rp, data_2rp},
                     {valid_1rp, data_1rp}, {valid_0rp, data_0rp}};
   assign push    = word_valid(rp_word);
   assign pop_ok  = pop && !fifo_empty;
   assign push_wr = push && (!fifo_full || pop_ok);

   recirculacion_retorno_fifo_recirc #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo_recirc (
      .clk       (clk),
      .reset_L   (reset_L),
      .push      (push),
      .wr_word   (rp_word),
      .pop       (pop),
      .rd_word   (rd_word),
      .count     (fifo_count),
      .count_nxt (count_nxt),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // state_q records whether the FIFO holds words; IDLE_OUT is applied live so a
   // rising IDLE_OUT switches to replay in the same cycle and nothing new slips ahead.
   always_comb begin
      state_d = PASS;
      if (count_nxt != '0) state_d = IDLE_OUT ? REPLAY : RECIRC;
   end

   always_comb begin
      mode           = state_q;
      ready_in       = 1'b0;
      pop            = 1'b0;
      ps_d           = '0;
      overflow_err_d = overflow_err_q | (push && fifo_full && !pop_ok);
      if (state_q != PASS) mode = IDLE_OUT ? REPLAY : RECIRC;
      unique case (mode)
         PASS: begin
            ready_in = 1'b1;
            if (word_valid(in_word)) ps_d = in_word;
         end
         RECIRC: begin
            ready_in = (fifo_count < RESERVE_LIM);
            if (ready_in && word_valid(in_word)) ps_d = in_word;
         end
         REPLAY: begin
            pop  = 1'b1;
            ps_d = rd_word;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q        <= PASS;
         ps_q           <= '0;
         overflow_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         ps_q           <= ps_d;
         overflow_err_q <= overflow_err_d;
      end
   end

   assign {valid_3ps, data_3ps, valid_2ps, data_2ps,
           valid_1ps, data_1ps, valid_0ps, data_0ps} = ps_q;
   assign overflow_err = overflow_err_q;

`ifdef RECIRC_STATS_EN
   logic [15:0] recirc_total_q, recirc_total_d;
   logic [AW:0] max_count_q, max_count_d;

   always_comb begin
      recirc_total_d = recirc_total_q;
      if (push_wr && recirc_total_q != 16'hFFFF) recirc_total_d = recirc_total_q + 16'd1;
      max_count_d = (count_nxt > max_count_q) ? count_nxt : max_count_q;
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         recirc_total_q <= '0;
         max_count_q    <= '0;
      end else begin
         recirc_total_q <= recirc_total_d;
         max_count_q    <= max_count_d;
      end
   end

   assign recirc_total = recirc_total_q;
   assign max_count    = max_count_q;
`else
   logic unused_push_wr;
   assign unused_push_wr = push_wr;
`endif

endmodule

// File: tb/tb_recirculacion_retorno.sv
// Scoreboard bench: a queue-level model of the whole loop predicts ps/count/err each cycle.
module tb_recirculacion_retorno;
   import recirculacion_retorno_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   typedef struct {
      word_t ps;
      int    cnt;
      bit    err;
      int    total;
      int    maxc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_L = 1'b0;
   logic        idle_out = 1'b1;
   logic        force_rp = 1'b0;
   word_t       force_word = '0;
   word_t       in_w = '0;
   word_t       ps_w, rp_w;
   logic [7:0]  ps_data [LANES];
   logic        ps_valid [LANES];
   logic        ready_in;
   logic [AW:0] fifo_count;
   logic        overflow_err;
`ifdef RECIRC_STATS_EN
   logic [15:0] recirc_total;
   logic [AW:0] max_count;
`endif

   int errors = 0;
   int checks = 0;

   // Model: FIFO contents, the word currently on ps, sticky error, stats.
   word_t m_fifo [$];
   word_t m_ps = '0;
   bit    m_err = 1'b0;
   int    m_total = 0;
   int    m_max = 0;
   exp_t  exp_q [$];

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         ps_w[i].valid = ps_valid[i];
         ps_w[i].data  = ps_data[i];
      end
   end

   // Downstream demux: ps bounces back onto rp while IDLE_OUT=0, unless a push is forced.
   always_comb rp_w = force_rp ? force_word : (idle_out ? word_t'('0) : ps_w);

   recirculacion_retorno #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk          (clk),
      .reset_L      (reset_L),
      .data_0in     (in_w[0].data),
      .data_1in     (in_w[1].data),
      .data_2in     (in_w[2].data),
      .data_3in     (in_w[3].data),
      .valid_0in    (in_w[0].valid),
      .valid_1in    (in_w[1].valid),
      .valid_2in    (in_w[2].valid),
      .valid_3in    (in_w[3].valid),
      .ready_in     (ready_in),
      .data_0rp     (rp_w[0].data),
      .data_1rp     (rp_w[1].data),
      .data_2rp     (rp_w[2].data),
      .data_3rp     (rp_w[3].data),
      .valid_0rp    (rp_w[0].valid),
      .valid_1rp    (rp_w[1].valid),
      .valid_2rp    (rp_w[2].valid),
      .valid_3rp    (rp_w[3].valid),
      .IDLE_OUT     (idle_out),
      .data_0ps     (ps_data[0]),
      .data_1ps     (ps_data[1]),
      .data_2ps     (ps_data[2]),
      .data_3ps     (ps_data[3]),
      .valid_0ps    (ps_valid[0]),
      .valid_1ps    (ps_valid[1]),
      .valid_2ps    (ps_valid[2]),
      .valid_3ps    (ps_valid[3]),
`ifdef RECIRC_STATS_EN
      .recirc_total (recirc_total),
      .max_count    (max_count),
`endif
      .fifo_count   (fifo_count),
      .overflow_err (overflow_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic word_t mk(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3);
      word_t w;
      w[0] = '{valid: v[0], data: d0};
      w[1] = '{valid: v[1], data: d1};
      w[2] = '{valid: v[2], data: d2};
      w[3] = '{valid: v[3], data: d3};
      return w;
   endfunction

   function automatic word_t rand_word();
      word_t w;
      for (int i = 0; i < LANES; i++) begin
         w[i].valid = 1'($urandom_range(0, 1));
         w[i].data  = 8'($urandom);
      end
      return w;
   endfunction

   task automatic model_reset();
      m_fifo.delete();
      m_ps    = '0;
      m_err   = 1'b0;
      m_total = 0;
      m_max   = 0;
      exp_q.delete();
   endtask

   // One clock cycle: drive inputs, predict with the model, queue the expected result.
   task automatic cycle(input word_t w, input bit idle, input bit frc, input word_t fw);
      bit    ready;
      word_t next_ps, push_w;
      int    sz;
      in_w       = w;
      idle_out   = idle;
      force_rp   = frc;
      force_word = fw;
      #1;
      sz = m_fifo.size();
      if (sz == 0)    ready = 1'b1;
      else if (!idle) ready = (sz < DEPTH - 1);
      else            ready = 1'b0;
      check("ready_in", 64'(ready_in), 64'(ready));
      push_w = frc ? fw : (idle ? word_t'('0) : m_ps);
      if (sz > 0 && idle) next_ps = m_fifo.pop_front();
      else                next_ps = (ready && word_valid(w)) ? w : word_t'('0);
      if (word_valid(push_w)) begin
         if (m_fifo.size() < DEPTH) begin
            m_fifo.push_back(push_w);
            if (m_total < 65535) m_total++;
         end else begin
            m_err = 1'b1;
         end
      end
      if (m_fifo.size() > m_max) m_max = m_fifo.size();
      m_ps = next_ps;
      @(posedge clk);
      exp_q.push_back('{ps: next_ps, cnt: m_fifo.size(), err: m_err, total: m_total, maxc: m_max});
      #1;
   endtask

   task automatic idle_cycle(input bit idle);
      cycle('0, idle, 1'b0, '0);
   endtask

   task automatic drain();
      for (int i = 0; i < 4 * DEPTH && (m_fifo.size() != 0 || m_ps != '0); i++) idle_cycle(1'b1);
      idle_cycle(1'b1);
   endtask

   // Monitor: compares every presented ps word and status against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (reset_L && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("ps_word", 64'(ps_w), 64'(e.ps));
         check("fifo_count", 64'(fifo_count), 64'(e.cnt));
         check("overflow_err", 64'(overflow_err), 64'(e.err));
`ifdef RECIRC_STATS_EN
         check("recirc_total", 64'(recirc_total), 64'(e.total));
         check("max_count", 64'(max_count), 64'(e.maxc));
`endif
      end
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_ps", 64'(ps_w), 64'd0);
      check("rst_count", 64'(fifo_count), 64'd0);
      check("rst_err", 64'(overflow_err), 64'd0);
      reset_L = 1'b1;

      // Straight pass-through with IDLE_OUT=1.
      cycle(mk(4'hF, 8'hA1, 8'hA2, 8'hA3, 8'hA4), 1'b1, 1'b0, '0);
      cycle(mk(4'h5, 8'hB1, 8'hB2, 8'hB3, 8'hB4), 1'b1, 1'b0, '0);
      idle_cycle(1'b1);

      // Single recirculated word pushed from rp.
      cycle('0, 1'b0, 1'b1, mk(4'hF, 8'h11, 8'h22, 8'h33, 8'h44));
      idle_cycle(1'b0);
      drain();

      // Three-word stream bounces, ready drops at count 3, then ordered replay.
      cycle(mk(4'hF, 8'hC1, 8'hC1, 8'hC1, 8'hC1), 1'b0, 1'b0, '0);
      cycle(mk(4'h3, 8'hC2, 8'hC2, 8'hC2, 8'hC2), 1'b0, 1'b0, '0);
      cycle(mk(4'h8, 8'hC3, 8'hC3, 8'hC3, 8'hC3), 1'b0, 1'b0, '0);
      idle_cycle(1'b0);
      cycle(mk(4'hF, 8'hC4, 8'hC4, 8'hC4, 8'hC4), 1'b0, 1'b0, '0);
      for (int i = 0; i < 4; i++) cycle(mk(4'hF, 8'hD0, 8'hD1, 8'hD2, 8'hD3), 1'b1, 1'b0, '0);
      drain();

      // Fill to DEPTH, then force a push into the full FIFO.
      for (int i = 0; i < 5; i++)
         cycle(mk(4'hF, 8'(8'hE0 + i), 8'hE5, 8'hE6, 8'hE7), 1'b0, 1'b0, '0);
      idle_cycle(1'b0);
      cycle('0, 1'b0, 1'b1, mk(4'hF, 8'hEE, 8'hEE, 8'hEE, 8'hEE));
      idle_cycle(1'b0);
      drain();

      // Reset in the middle of a replay with two words left.
      @(posedge clk);
      reset_L = 1'b0;
      #1;
      model_reset();
      reset_L = 1'b1;
      for (int i = 0; i < 3; i++) cycle(mk(4'hF, 8'(8'h70 + i), 8'h71, 8'h72, 8'h73), 1'b0, 1'b0, '0);
      idle_cycle(1'b0);
      idle_cycle(1'b1);
      check("pre_rst_count", 64'(fifo_count), 64'd2);
      reset_L = 1'b0;
      #1;
      check("mid_rst_ps", 64'(ps_w), 64'd0);
      check("mid_rst_count", 64'(fifo_count), 64'd0);
      check("mid_rst_err", 64'(overflow_err), 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset_L = 1'b1;

      // Randomized traffic with IDLE_OUT toggling, including mid-replay.
      begin
         bit idle;
         idle = 1'b1;
         for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) idle = ~idle;
            cycle(rand_word(), idle, 1'b0, '0);
         end
      end
      drain();

      #2;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
